disp_vramarb: RTL and testbench
===============================

// Module: disp_vramarb
// PURPOSE
//  2:1 AXI4 read-channel arbiter sharing the single VRAM read port between the display VRAM read
//  controller (M0) and a second requester, the drawing engine (M1). One burst in flight at a time.
//  Grant is held from AR acceptance until the last R beat. Round-robin between requesters.
//  A sticky error flag reports bursts whose RLAST disagrees with the captured ARLEN.
// PARAMETERS
//  ADDR_W  32  AR address width
//  DATA_W  64  R data width
// PORTS
//  ACLK          in   1       clock
//  ARST          in   1       reset, synchronous, active-high
//  M0_ARADDR     in   ADDR_W  display read address
//  M0_ARLEN      in   8       display burst length-1
//  M0_ARVALID    in   1       display AR valid
//  M0_ARREADY    out  1       display AR ready
//  M0_RDATA      out  DATA_W  display read data
//  M0_RLAST      out  1       display last beat
//  M0_RVALID     out  1       display R valid
//  M0_RREADY     in   1       display R ready
//  M1_*          same set as M0_*, drawing-engine side
//  S_ARADDR      out  ADDR_W  to VRAM AR
//  S_ARLEN       out  8       to VRAM AR
//  S_ARVALID     out  1       to VRAM AR
//  S_ARREADY     in   1       from VRAM AR
//  S_RDATA       in   DATA_W  from VRAM R
//  S_RLAST       in   1       from VRAM R
//  S_RVALID      in   1       from VRAM R
//  S_RREADY      out  1       to VRAM R
//  LENERR        out  1       sticky: burst beat count != ARLEN+1
// BEHAVIOUR
//  - FSM states: IDLE, ADDR, DATA (one-hot).
//  - Reset values: state IDLE, last_gnt=M1 (so M0 wins first contention), gnt=M0, LENERR=0,
//    all registered AR outputs 0, S_ARVALID=0, beat counter 0.
//  - IDLE: winner = sole valid requester. On both valid, winner = the master not in last_gnt.
//    Winner's Mx_ARREADY=1 in the same cycle (combinational on ARVALID); the loser's ARREADY is 0.
//    On a handshake: capture ARADDR/ARLEN into S_ARADDR/S_ARLEN, gnt<=winner, clear beat counter,
//    go to ADDR. No ARVALID -> stay in IDLE.
//  - ADDR: S_ARVALID=1, holding S_ARADDR/S_ARLEN stable. On S_ARREADY -> DATA and S_ARVALID drops
//    next cycle. Latency Mx_ARVALID(n) -> S_ARVALID(n+1) minimum.
//  - DATA: combinational routing. Mgnt_RDATA/RLAST/RVALID = S_*. Other master's RVALID=0, its
//    RLAST=0, its RDATA=S_RDATA. S_RREADY = Mgnt_RREADY.
//  - DATA beat accept (S_RVALID & S_RREADY): beat counter +1 (9-bit).
//  - Last beat accepted (S_RLAST): if counter != S_ARLEN then LENERR<=1. last_gnt<=gnt. -> IDLE.
//    A new grant is possible at the earliest in the following cycle (1 idle bubble).
//  - Counter reaching S_ARLEN+1 with no RLAST: LENERR<=1. Stay in DATA until RLAST; the counter
//    saturates at 9'h1FF.
//  - Mx_ARREADY=0 and all Mx_RVALID=0 in ADDR and DATA. S_RREADY=0 outside DATA.
//  - Requests arriving during ADDR/DATA stay pending on the master side. This arbiter has no
//    queueing.
//  - Reset mid-burst: immediate return to IDLE with reset values. The system resets VRAM and both
//    masters together, so an abandoned burst is not completed.
//  - LENERR cleared only by ARST.
// STRUCTURE
//  - Shared package disp_pkg: state one-hot encodings (ST_IDLE/ST_ADDR/ST_DATA), master index
//    constants (MST_DISP=0, MST_DRAW=1), AXI ARLEN width constant.
//  - One natural sub-module: disp_rr_sel. 2-way round-robin picker (req[1:0], last_gnt -> gnt_oh);
//    purely combinational, reusable for future masters.
// TESTING
//  1 M0 only: ARADDR=32'h1000_0000, ARLEN=7 -> M0_ARREADY same cycle, S_ARVALID next cycle with the
//    same address/len; 8 beats routed to M0, LENERR=0.
//  2 M0,M1 both valid from reset -> M0 granted first; after its RLAST, M1 granted next (IDLE
//    bubble of 1 cycle); then M0 again if both still valid.
//  3 M1 request arriving during M0 DATA -> M1_ARREADY stays 0 until M0 RLAST accepted; M1_RVALID=0
//    throughout M0 burst.
//  4 Backpressure: M0_RREADY toggles 1/0 each cycle during 8-beat burst -> S_RREADY mirrors it,
//    no beat lost or duplicated, burst completes in 16 cycles.
//  5 Slave returns RLAST on beat 4 for ARLEN=7 -> LENERR=1 at next cycle, FSM back to IDLE;
//    LENERR remains 1 over later good bursts until ARST.
//  6 ARST asserted in DATA mid-burst -> next cycle IDLE, S_RREADY=0, S_ARVALID=0, LENERR=0; next
//    contention grants M0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the display VRAM read-path blocks.
package disp_pkg;

  localparam int AXI_LEN_W = 8;
  localparam int BEAT_CNT_W = AXI_LEN_W + 1;

  localparam logic MST_DISP = 1'b0;
  localparam logic MST_DRAW = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_ADDR = 3'b010,
    ST_DATA = 3'b100
  } arb_state_e;

endpackage

// File: rtl/disp_rr_sel.sv
// Two-way round-robin picker: the requester that was not served last wins a tie.
module disp_rr_sel
  import disp_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt_oh
);

  always_comb begin
    // NOTE: default first so no path leaves gnt_oh unassigned and no latch is inferred.
    gnt_oh = 2'b00;
    if (req == 2'b11) begin
      gnt_oh = (last_gnt == MST_DISP) ? 2'b10 : 2'b01;
    end else begin
      gnt_oh = req;
    end
  end

endmodule

// File: rtl/disp_vramarb.sv
// 2:1 AXI4 read arbiter for the VRAM read port; one burst in flight, grant held until RLAST.
module disp_vramarb
  import disp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                 ACLK,
  input  logic                 ARST,

  input  logic [ADDR_W-1:0]    M0_ARADDR,
  input  logic [AXI_LEN_W-1:0] M0_ARLEN,
  input  logic                 M0_ARVALID,
  output logic                 M0_ARREADY,
  output logic [DATA_W-1:0]    M0_RDATA,
  output logic                 M0_RLAST,
  output logic                 M0_RVALID,
  input  logic                 M0_RREADY,

  input  logic [ADDR_W-1:0]    M1_ARADDR,
  input  logic [AXI_LEN_W-1:0] M1_ARLEN,
  input  logic                 M1_ARVALID,
  output logic                 M1_ARREADY,
  output logic [DATA_W-1:0]    M1_RDATA,
  output logic                 M1_RLAST,
  output logic                 M1_RVALID,
  input  logic                 M1_RREADY,

  output logic [ADDR_W-1:0]    S_ARADDR,
  output logic [AXI_LEN_W-1:0] S_ARLEN,
  output logic                 S_ARVALID,
  input  logic                 S_ARREADY,
  input  logic [DATA_W-1:0]    S_RDATA,
  input  logic                 S_RLAST,
  input  logic                 S_RVALID,
  output logic                 S_RREADY,

  output logic                 LENERR
);

  arb_state_e            state;
  logic                  gnt;
  logic                  last_gnt;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] len_ext;

  logic [1:0] gnt_oh;
  logic       in_idle;
  logic       in_data;
  logic       hs0;
  logic       hs1;
  logic       gnt_rready;
  logic       beat;

  disp_rr_sel u_rr_sel (
    .req      ({M1_ARVALID, M0_ARVALID}),
    .last_gnt (last_gnt),
    .gnt_oh   (gnt_oh)
  );

  assign in_idle = (state == ST_IDLE);
  assign in_data = (state == ST_DATA);

  assign M0_ARREADY = in_idle & gnt_oh[0];
  assign M1_ARREADY = in_idle & gnt_oh[1];
  assign hs0        = M0_ARVALID & M0_ARREADY;
  assign hs1        = M1_ARVALID & M1_ARREADY;

  // Read data fans out to both masters; only the granted side ever sees RVALID/RLAST.
  assign gnt_rready = (gnt == MST_DRAW) ? M1_RREADY : M0_RREADY;
  assign S_RREADY   = in_data & gnt_rready;
  assign M0_RDATA   = S_RDATA;
  assign M1_RDATA   = S_RDATA;
  assign M0_RVALID  = in_data & (gnt == MST_DISP) & S_RVALID;
  assign M1_RVALID  = in_data & (gnt == MST_DRAW) & S_RVALID;
  assign M0_RLAST   = in_data & (gnt == MST_DISP) & S_RLAST;
  assign M1_RLAST   = in_data & (gnt == MST_DRAW) & S_RLAST;

  assign beat    = S_RVALID & S_RREADY;
  assign len_ext = {1'b0, S_ARLEN};

  // NOTE: all state uses <= so every branch below reads the values from before this edge.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= ST_IDLE;
      gnt       <= MST_DISP;
      last_gnt  <= MST_DRAW;
      beat_cnt  <= '0;
      S_ARADDR  <= '0;
      S_ARLEN   <= '0;
      S_ARVALID <= 1'b0;
      LENERR    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hs0 || hs1) begin
            S_ARADDR  <= hs1 ? M1_ARADDR : M0_ARADDR;
            S_ARLEN   <= hs1 ? M1_ARLEN : M0_ARLEN;
            gnt       <= hs1 ? MST_DRAW : MST_DISP;
            beat_cnt  <= '0;
            S_ARVALID <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            // beat_cnt counts beats before this one, so the last beat must see exactly ARLEN.
            if (S_RLAST) begin
              if (beat_cnt != len_ext) LENERR <= 1'b1;
              last_gnt <= gnt;
              state    <= ST_IDLE;
            end else if (beat_cnt >= len_ext) begin
              LENERR <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_vramarb.sv
// Random traffic on both masters and the VRAM slave, checked each cycle against a burst-level model.
module tb_disp_vramarb;
  import disp_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int N_CYC  = 6000;

  logic              ACLK = 1'b0;
  logic              ARST;
  logic [ADDR_W-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
  logic [7:0]        M0_ARLEN, M1_ARLEN, S_ARLEN;
  logic              M0_ARVALID, M0_ARREADY, M0_RLAST, M0_RVALID, M0_RREADY;
  logic              M1_ARVALID, M1_ARREADY, M1_RLAST, M1_RVALID, M1_RREADY;
  logic [DATA_W-1:0] M0_RDATA, M1_RDATA, S_RDATA;
  logic              S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY, LENERR;

  always #5 ACLK = ~ACLK;

  disp_vramarb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .LENERR(LENERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Burst-level model: whether a burst is in flight, whether its address went out, whom it serves.
  bit          busy, ar_done, m_lenerr;
  int          cur, last_gnt, beats;
  logic [31:0] m_addr;
  logic [7:0]  m_len;

  // Master-side pending requests and slave-side beat plan.
  bit          pend [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_len [2];
  bit          rr [2];
  int          s_left;
  bit          s_hold;
  logic [63:0] s_data;
  bit          s_last;
  bit          post_rst;

  task automatic model_reset();
    busy = 0; ar_done = 0; m_lenerr = 0; cur = 0; last_gnt = 1; beats = 0;
    m_addr = '0; m_len = '0; s_left = 0; s_hold = 0;
    pend[0] = 0; pend[1] = 0;
  endtask

  task automatic new_req(input int m);
    pend[m]   = 1;
    p_addr[m] = $urandom;
    p_len[m]  = 8'($urandom_range(7));
  endtask

  initial begin
    int  win;
    bit  rst_now, data_ph;
    int  mode, n;

    ARST = 1'b1;
    {M0_ARADDR, M0_ARLEN, M0_ARVALID, M0_RREADY} = '0;
    {M1_ARADDR, M1_ARLEN, M1_ARVALID, M1_RREADY} = '0;
    {S_ARREADY, S_RDATA, S_RLAST, S_RVALID} = '0;
    model_reset();
    repeat (3) @(posedge ACLK);
    post_rst = 1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge ACLK);
      rst_now = ($urandom_range(499) == 0);
      ARST = rst_now;

      // Right after reset both masters contend so the first grant after reset is exercised.
      if (post_rst) begin
        new_req(0);
        new_req(1);
        post_rst = 0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(3) == 0) new_req(m);
        rr[m] = ($urandom_range(3) != 0);
      end
      if (rst_now) begin
        pend[0] = 0;
        pend[1] = 0;
      end
      M0_ARVALID = pend[0]; M0_ARADDR = p_addr[0]; M0_ARLEN = p_len[0]; M0_RREADY = rr[0];
      M1_ARVALID = pend[1]; M1_ARADDR = p_addr[1]; M1_ARLEN = p_len[1]; M1_RREADY = rr[1];

      data_ph = busy && ar_done;
      S_ARREADY = 1'($urandom_range(1));
      if (data_ph && s_left > 0 && !s_hold && $urandom_range(2) != 0) begin
        s_hold = 1;
        s_data = {$urandom, $urandom};
        s_last = (s_left == 1);
      end
      S_RVALID = s_hold;
      S_RDATA  = s_hold ? s_data : {$urandom, $urandom};
      S_RLAST  = s_hold ? s_last : 1'($urandom_range(1));

      #1;
      win = -1;
      if (!busy) begin
        if (M0_ARVALID && M1_ARVALID) win = (last_gnt == 1) ? 0 : 1;
        else if (M0_ARVALID)          win = 0;
        else if (M1_ARVALID)          win = 1;
      end
      check("m0_arready", 64'(M0_ARREADY), 64'(win == 0));
      check("m1_arready", 64'(M1_ARREADY), 64'(win == 1));
      check("s_arvalid",  64'(S_ARVALID),  64'(busy && !ar_done));
      check("s_araddr",   64'(S_ARADDR),   64'(m_addr));
      check("s_arlen",    64'(S_ARLEN),    64'(m_len));
      check("s_rready",   64'(S_RREADY),   64'(data_ph && rr[cur]));
      check("m0_rvalid",  64'(M0_RVALID),  64'(data_ph && cur == 0 && S_RVALID));
      check("m1_rvalid",  64'(M1_RVALID),  64'(data_ph && cur == 1 && S_RVALID));
      check("m0_rlast",   64'(M0_RLAST),   64'(data_ph && cur == 0 && S_RLAST));
      check("m1_rlast",   64'(M1_RLAST),   64'(data_ph && cur == 1 && S_RLAST));
      if (data_ph) begin
        check("m0_rdata", M0_RDATA, S_RDATA);
        check("m1_rdata", M1_RDATA, S_RDATA);
      end
      check("lenerr", 64'(LENERR), 64'(m_lenerr));

      // Masters react to the ready they actually see; the model advances on its own rules.
      if (M0_ARVALID && M0_ARREADY) pend[0] = 0;
      if (M1_ARVALID && M1_ARREADY) pend[1] = 0;

      if (rst_now) begin
        model_reset();
        post_rst = 1;
      end else if (!busy) begin
        if (win >= 0) begin
          busy = 1; ar_done = 0; cur = win; beats = 0;
          m_addr = p_addr[win];
          m_len  = p_len[win];
        end
      end else if (!ar_done) begin
        if (S_ARREADY) begin
          ar_done = 1;
          mode = $urandom_range(11);
          n = int'(m_len) + 1;
          if (mode == 0 && m_len > 0) n = 1 + $urandom_range(int'(m_len) - 1);
          else if (mode == 1)         n = int'(m_len) + 2;
          s_left = n;
        end
      end else if (S_RVALID && rr[cur]) begin
        beats++;
        s_hold = 0;
        s_left--;
        if (S_RLAST) begin
          if (beats != int'(m_len) + 1) m_lenerr = 1;
          last_gnt = cur;
          busy = 0;
          ar_done = 0;
        end else if (beats > int'(m_len)) begin
          m_lenerr = 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
